// File: rtl/alu_operand_fetch_if.sv
// alu_operand_fetch_if: groups the register-file write port, the fetch request and the ALU operand outputs.
//   master: drives wr_en/wr_addr/wr_data, start, rn, rm, shift, asel, bsel, sximm5, op_in;
//           observes busy, valid, Ain, Bin, ALUop.
//   slave : the operand-fetch stage (mirror directions).
interface alu_operand_fetch_if #(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 8
);
    localparam int AW = $clog2(REG_CNT);
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic [AW-1:0]     rn;
    logic [AW-1:0]     rm;
    logic [1:0]        shift;
    logic              asel;
    logic              bsel;
    logic [DATA_W-1:0] sximm5;
    logic [1:0]        op_in;
    logic              busy;
    logic              valid;
    logic [DATA_W-1:0] Ain;
    logic [DATA_W-1:0] Bin;
    logic [1:0]        ALUop;
    modport master (
        output wr_en, wr_addr, wr_data, start, rn, rm, shift, asel, bsel, sximm5, op_in,
        input  busy, valid, Ain, Bin, ALUop
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, start, rn, rm, shift, asel, bsel, sximm5, op_in,
        output busy, valid, Ain, Bin, ALUop
    );
endinterface

// File: rtl/alu_operand_fetch.sv
// alu_operand_fetch: register file plus two-cycle single-port operand fetch, shifter and A/B selects feeding the ALU.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : alu_operand_fetch_if.slave (write port, fetch request, busy/valid, Ain/Bin/ALUop)
//   Optional macro OPFETCH_FWD_EN: a read colliding with a same-cycle write returns the write data.
module alu_operand_fetch #(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 8
) (
    input logic              clk,
    input logic              reset_n,
    alu_operand_fetch_if.slave bus
);
    localparam int AW = $clog2(REG_CNT);

    typedef enum logic [1:0] {IDLE, READ_A, READ_B, PRESENT} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic [AW-1:0]     rn_q, rm_q;
    logic [1:0]        shift_q, op_q, aluop_q;
    logic              asel_q, bsel_q;
    logic [DATA_W-1:0] imm_q, a_q, ain_q, bin_q;
    logic              accept;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data, shifted;

    // A new request is taken only from IDLE or PRESENT; start while reading is dropped.
    always_comb begin
        accept  = bus.start && (state_q == IDLE || state_q == PRESENT);
        state_d = state_q;
        case (state_q)
            READ_A:  state_d = READ_B;
            READ_B:  state_d = PRESENT;
            default: state_d = accept ? READ_A : IDLE;
        endcase
    end

    // Single read port: rn in READ_A, rm otherwise (only consumed in READ_B).
    assign rd_addr = (state_q == READ_A) ? rn_q : rm_q;
`ifdef OPFETCH_FWD_EN
    assign rd_data = (bus.wr_en && bus.wr_addr == rd_addr) ? bus.wr_data : regs_q[rd_addr];
`else
    assign rd_data = regs_q[rd_addr];
`endif

    assign shifted = shift_q == 2'b01 ? {rd_data[DATA_W-2:0], 1'b0} :
                     shift_q == 2'b10 ? {1'b0, rd_data[DATA_W-1:1]} :
                     shift_q == 2'b11 ? {rd_data[DATA_W-1], rd_data[DATA_W-1:1]} :
                                        rd_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rn_q    <= '0;
            rm_q    <= '0;
            shift_q <= '0;
            asel_q  <= 1'b0;
            bsel_q  <= 1'b0;
            imm_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            ain_q   <= '0;
            bin_q   <= '0;
            aluop_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rn_q    <= bus.rn;
                rm_q    <= bus.rm;
                shift_q <= bus.shift;
                asel_q  <= bus.asel;
                bsel_q  <= bus.bsel;
                imm_q   <= bus.sximm5;
                op_q    <= bus.op_in;
            end
            if (state_q == READ_A) a_q <= rd_data;
            if (state_q == READ_B) begin
                ain_q   <= asel_q ? '0 : a_q;
                bin_q   <= bsel_q ? imm_q : shifted;
                aluop_q <= op_q;
            end
        end
    end

    // Writes are independent of the fetch FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_CNT; i++) regs_q[i] <= '0;
        end else if (bus.wr_en) begin
            regs_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.busy  = (state_q == READ_A) || (state_q == READ_B);
    assign bus.valid = (state_q == PRESENT);
    assign bus.Ain   = ain_q;
    assign bus.Bin   = bin_q;
    assign bus.ALUop = aluop_q;
endmodule

// File: tb/tb_alu_operand_fetch.sv
// tb_alu_operand_fetch: directed self-checking bench for alu_operand_fetch.
module tb_alu_operand_fetch;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   vcnt;

    always #5 clk = ~clk;

    alu_operand_fetch_if #(.DATA_W(16), .REG_CNT(8)) bus ();

    alu_operand_fetch #(.DATA_W(16), .REG_CNT(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic req(input logic [2:0] rn, input logic [2:0] rm, input logic [1:0] sh,
                       input logic as, input logic bs, input logic [15:0] imm, input logic [1:0] op);
        bus.start  = 1'b1;
        bus.rn     = rn;
        bus.rm     = rm;
        bus.shift  = sh;
        bus.asel   = as;
        bus.bsel   = bs;
        bus.sximm5 = imm;
        bus.op_in  = op;
    endtask

    // Full fetch from IDLE: busy for 2 cycles, valid in cycle 3, back to IDLE.
    task automatic fetch(input string tag, input logic [2:0] rn, input logic [2:0] rm, input logic [1:0] sh,
                         input logic as, input logic bs, input logic [15:0] imm, input logic [1:0] op,
                         input logic [15:0] ea, input logic [15:0] eb);
        req(rn, rm, sh, as, bs, imm, op);
        tick();
        bus.start = 1'b0;
        chk({tag, "_c1_busy"}, 16'(bus.busy), 16'd1);
        chk({tag, "_c1_valid"}, 16'(bus.valid), 16'd0);
        tick();
        chk({tag, "_c2_busy"}, 16'(bus.busy), 16'd1);
        chk({tag, "_c2_valid"}, 16'(bus.valid), 16'd0);
        tick();
        chk({tag, "_c3_valid"}, 16'(bus.valid), 16'd1);
        chk({tag, "_c3_busy"}, 16'(bus.busy), 16'd0);
        chk({tag, "_ain"}, bus.Ain, ea);
        chk({tag, "_bin"}, bus.Bin, eb);
        chk({tag, "_op"}, 16'(bus.ALUop), 16'(op));
        tick();
        chk({tag, "_idle_valid"}, 16'(bus.valid), 16'd0);
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        req(3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_valid", 16'(bus.valid), 16'd0);
        chk("rst_ain", bus.Ain, 16'h0);
        chk("rst_bin", bus.Bin, 16'h0);
        chk("rst_op", 16'(bus.ALUop), 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        wr(3'd0, 16'd5);
        wr(3'd1, 16'd3);
        wr(3'd2, 16'h8001);
        fetch("basic", 3'd0, 3'd1, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00, 16'd5, 16'd3);
        fetch("shl", 3'd0, 3'd2, 2'b01, 1'b0, 1'b0, 16'h0, 2'b01, 16'd5, 16'h0002);
        fetch("lsr", 3'd0, 3'd2, 2'b10, 1'b0, 1'b0, 16'h0, 2'b10, 16'd5, 16'h4000);
        fetch("asr", 3'd0, 3'd2, 2'b11, 1'b0, 1'b0, 16'h0, 2'b00, 16'd5, 16'hC000);
        fetch("sel", 3'd0, 3'd2, 2'b01, 1'b1, 1'b1, 16'hFFF0, 2'b11, 16'h0, 16'hFFF0);

        // start held high: one result every third cycle, outputs stable in between
        req(3'd1, 3'd0, 2'b00, 1'b0, 1'b0, 16'h0, 2'b01);
        vcnt = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (bus.valid) vcnt++;
            chk($sformatf("hold_valid_k%0d", k), 16'(bus.valid), 16'((k % 3) == 0));
            if (k >= 3) begin
                chk($sformatf("hold_ain_k%0d", k), bus.Ain, 16'd3);
                chk($sformatf("hold_bin_k%0d", k), bus.Bin, 16'd5);
            end
        end
        chk("hold_count", 16'(vcnt), 16'd3);
        bus.start = 1'b0;
        tick();
        chk("hold_end_valid", 16'(bus.valid), 16'd0);
        chk("hold_end_busy", 16'(bus.busy), 16'd0);

        // start pulses while reading are ignored and do not relatch the request
        req(3'd0, 3'd1, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00);
        tick();
        req(3'd2, 3'd2, 2'b11, 1'b1, 1'b1, 16'h1234, 2'b11);
        tick();
        tick();
        bus.start = 1'b0;
        chk("ign_valid", 16'(bus.valid), 16'd1);
        chk("ign_ain", bus.Ain, 16'd5);
        chk("ign_bin", bus.Bin, 16'd3);
        chk("ign_op", 16'(bus.ALUop), 16'd0);
        tick();
        chk("ign_after_valid", 16'(bus.valid), 16'd0);
        tick();
        chk("ign_after2_valid", 16'(bus.valid), 16'd0);
        chk("ign_after2_busy", 16'(bus.busy), 16'd0);

        // write to r0 during READ_A of a fetch reading r0
        req(3'd0, 3'd1, 2'b00, 1'b0, 1'b0, 16'h0, 2'b10);
        tick();
        bus.start = 1'b0;
        bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 16'h00AA;
        tick();
        bus.wr_en = 1'b0;
        tick();
        chk("fwd_valid", 16'(bus.valid), 16'd1);
`ifdef OPFETCH_FWD_EN
        chk("fwd_ain", bus.Ain, 16'h00AA);
`else
        chk("fwd_ain", bus.Ain, 16'd5);
`endif
        chk("fwd_bin", bus.Bin, 16'd3);
        tick();

        // reset asserted during READ_B
        req(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0, 2'b01);
        tick();
        bus.start = 1'b0;
        tick();
        chk("mid_busy_pre", 16'(bus.busy), 16'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_busy", 16'(bus.busy), 16'd0);
        chk("mid_valid", 16'(bus.valid), 16'd0);
        chk("mid_ain", bus.Ain, 16'h0);
        chk("mid_bin", bus.Bin, 16'h0);
        chk("mid_op", 16'(bus.ALUop), 16'h0);
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.valid || bus.busy) vcnt++;
        end
        chk("mid_no_result", 16'(vcnt), 16'd0);

        // registers cleared by reset; rn == rm reads the same register
        wr(3'd3, 16'd7);
        fetch("same", 3'd3, 3'd3, 2'b10, 1'b0, 1'b0, 16'h0, 2'b01, 16'd7, 16'd3);
        fetch("clr", 3'd0, 3'd1, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
